// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative unsigned restoring divider. Retires one quotient
//                bit per clock; each trial subtraction is the divisor's
//                one's complement added with carry-in 1 (borrow = !carry).
//                Valid/ready handshakes on both the operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w   = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [WIDTH+1:0]   c_cin     = (WIDTH + 2)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_d;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH:0]       r_r;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_div_by_zero;

    logic [WIDTH:0]       w_s;
    logic [WIDTH+1:0]     w_sum;
    logic                 w_carry;
    logic [WIDTH:0]       w_r_next;
    logic [WIDTH-1:0]     w_q_next;
    logic                 w_unused_r_msb;

    // Shift the next dividend bit into the partial remainder, then trial-subtract
    // the divisor. The extra remainder bit keeps an MSB-set divisor from
    // overflowing; the carry out of the widened sum is the "no borrow" flag.
    assign w_s      = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_sum    = {1'b0, w_s} + {1'b0, ~{1'b0, r_d}} + c_cin;
    assign w_carry  = w_sum[WIDTH+1];
    assign w_r_next = w_carry ? w_sum[WIDTH:0] : w_s;
    assign w_q_next = {r_q[WIDTH-2:0], w_carry};

    // A restored remainder is always below the divisor, so its top bit stays 0.
    assign w_unused_r_msb = r_r[WIDTH];

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_d           <= '0;
            r_q           <= '0;
            r_r           <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_d   <= divisor;
                        r_q   <= dividend;
                        r_r   <= '0;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            // Nothing to iterate: present the saturated result now.
                            r_state       <= DONE;
                            r_out_valid   <= 1'b1;
                            r_quotient    <= '1;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last) begin
                        r_state       <= DONE;
                        r_out_valid   <= 1'b1;
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_r_next[WIDTH-1:0];
                        r_div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    // Result data is left untouched so it stays stable under backpressure.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
